// File: rtl/d_branch_predict_cmp.sv
// Decode-stage branch resolver: evaluates the branch condition, keeps a PC-indexed
// table of 2-bit saturating direction counters, and keeps branch/miss statistics.
module d_branch_predict_cmp #(
  parameter int         WIDTH    = 32,
  parameter int         IDX_BITS = 6,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      f_pc,
  output logic             f_pred_taken,
  input  logic             d_valid,
  input  logic             d_stall,
  input  logic [31:0]      d_pc,
  input  logic             d_pred_taken,
  input  logic [3:0]       brOp,
  input  logic [WIDTH-1:0] cmp1,
  input  logic [WIDTH-1:0] cmp2,
  output logic             isBr,
  output logic             mispredict,
  output logic [31:0]      br_cnt,
  output logic [31:0]      miss_cnt
);

  localparam logic [3:0] CMP_BEQ    = 4'd1;
  localparam logic [3:0] CMP_BNE    = 4'd2;
  localparam logic [3:0] CMP_BGEZ   = 4'd3;
  localparam logic [3:0] CMP_BGTZ   = 4'd4;
  localparam logic [3:0] CMP_BLEZ   = 4'd5;
  localparam logic [3:0] CMP_BLTZ   = 4'd6;
  localparam logic [3:0] CMP_BGEZAL = 4'd7;
  localparam logic [3:0] CMP_BLTZAL = 4'd8;

  localparam int DEPTH = 1 << IDX_BITS;

  logic [1:0]          ctr_tbl [DEPTH];
  logic [IDX_BITS-1:0] f_idx;
  logic [IDX_BITS-1:0] d_idx;
  logic                is_branch;
  logic                qualified;
  logic                neg;
  logic                zero;
  logic                unused_pc_bits;

  assign f_idx = f_pc[IDX_BITS+1:2];
  assign d_idx = d_pc[IDX_BITS+1:2];
  // Upper PC bits are deliberately ignored; aliasing between PCs is accepted.
  assign unused_pc_bits = ^{f_pc[31:IDX_BITS+2], f_pc[1:0], d_pc[31:IDX_BITS+2], d_pc[1:0]};

  assign f_pred_taken = ctr_tbl[f_idx][1];

  assign neg  = cmp1[WIDTH-1];
  assign zero = (cmp1 == '0);

  always_comb begin
    is_branch = 1'b1;
    isBr      = 1'b0;
    case (brOp)
      CMP_BEQ:                isBr = (cmp1 == cmp2);
      CMP_BNE:                isBr = (cmp1 != cmp2);
      CMP_BGEZ, CMP_BGEZAL:   isBr = ~neg;
      CMP_BGTZ:               isBr = ~neg & ~zero;
      CMP_BLEZ:               isBr = neg | zero;
      CMP_BLTZ, CMP_BLTZAL:   isBr = neg;
      default:                is_branch = 1'b0;
    endcase
  end

  assign qualified  = d_valid & ~d_stall & is_branch;
  assign mispredict = qualified & (isBr != d_pred_taken);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctr_tbl[i] <= CTR_INIT;
    end else if (qualified) begin
      if (isBr) begin
        if (ctr_tbl[d_idx] != 2'b11) ctr_tbl[d_idx] <= ctr_tbl[d_idx] + 2'b01;
      end else begin
        if (ctr_tbl[d_idx] != 2'b00) ctr_tbl[d_idx] <= ctr_tbl[d_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (qualified) begin
      if (br_cnt != 32'hFFFF_FFFF) br_cnt <= br_cnt + 32'd1;
      if (mispredict && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_d_branch_predict_cmp.sv
// Self-checking bench for d_branch_predict_cmp: vector table, directed corner
// sequences and randomized traffic against a behavioural predictor model.
module tb_d_branch_predict_cmp;

  localparam logic [3:0] BEQ = 4'd1, BNE = 4'd2, BGEZ = 4'd3, BGTZ = 4'd4,
                         BLEZ = 4'd5, BLTZ = 4'd6, BGEZAL = 4'd7, BLTZAL = 4'd8;

  logic        clk, reset;
  logic [31:0] f_pc, d_pc, cmp1, cmp2, br_cnt, miss_cnt;
  logic        f_pred_taken, d_valid, d_stall, d_pred_taken, isBr, mispredict;
  logic [3:0]  brOp;

  d_branch_predict_cmp dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .d_valid(d_valid), .d_stall(d_stall), .d_pc(d_pc), .d_pred_taken(d_pred_taken),
    .brOp(brOp), .cmp1(cmp1), .cmp2(cmp2), .isBr(isBr), .mispredict(mispredict),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          m_tbl [64];
  longint      m_br, m_miss;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] c1;
    logic [31:0] c2;
    logic        pred;
    logic        exp_br;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return (pc >> 2) % 64;
  endfunction

  // Returns {is_branch, taken} from the condition rules on signed operands.
  function automatic logic [1:0] ref_cond(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = int'(a);
    case (op)
      BEQ:            return {1'b1, a == b};
      BNE:            return {1'b1, a != b};
      BGEZ, BGEZAL:   return {1'b1, sa >= 0};
      BGTZ:           return {1'b1, sa > 0};
      BLEZ:           return {1'b1, sa <= 0};
      BLTZ, BLTZAL:   return {1'b1, sa < 0};
      default:        return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_tbl[i] = 1;
    m_br = 0;
    m_miss = 0;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] pc, input logic p,
                       input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    d_valid = v; d_stall = s; d_pc = pc; d_pred_taken = p; brOp = op; cmp1 = a; cmp2 = b;
  endtask

  // Called at posedge+1: checks combinational outputs, clocks once, checks state.
  task automatic cycle();
    logic [1:0] rc;
    logic       q, mis;
    #2;
    rc  = ref_cond(brOp, cmp1, cmp2);
    q   = d_valid && !d_stall && rc[1];
    mis = q && (rc[0] != d_pred_taken);
    chk("isBr", isBr, rc[0]);
    chk("mispredict", mispredict, mis);
    chk("f_pred_pre", f_pred_taken, m_tbl[idx_of(f_pc)] >= 2);
    @(posedge clk);
    #1;
    if (q) begin
      if (rc[0]) m_tbl[idx_of(d_pc)] = (m_tbl[idx_of(d_pc)] < 3) ? m_tbl[idx_of(d_pc)] + 1 : 3;
      else       m_tbl[idx_of(d_pc)] = (m_tbl[idx_of(d_pc)] > 0) ? m_tbl[idx_of(d_pc)] - 1 : 0;
      m_br++;
      if (mis) m_miss++;
    end
    chk("br_cnt", br_cnt, m_br[31:0]);
    chk("miss_cnt", miss_cnt, m_miss[31:0]);
    chk("f_pred_post", f_pred_taken, m_tbl[idx_of(f_pc)] >= 2);
  endtask

  initial begin
    vecs[0]  = '{BLTZ,   32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{BGTZ,   32'h0,         32'h0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{BLEZ,   32'h0,         32'h0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{4'hF,   32'h1,         32'h1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{BGEZ,   32'h0,         32'h0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{BGEZ,   32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{BNE,    32'h1,         32'h2, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{BEQ,    32'h1,         32'h2, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{BGTZ,   32'h1,         32'h0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{BLEZ,   32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{BLTZAL, 32'hFFFF_FFFB, 32'h0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{BGEZAL, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{4'h0,   32'h5,         32'h5, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{BGTZ,   32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    f_pc  = 32'h3000;
    drive(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    #1;
    chk("reset_f_pred", f_pred_taken, 1'b0);
    chk("reset_br_cnt", br_cnt, 32'd0);
    chk("reset_miss_cnt", miss_cnt, 32'd0);
    @(posedge clk); #1;

    // First taken branch, predicted not-taken.
    drive(1, 0, 32'h3000, 0, BEQ, 32'd5, 32'd5);
    #1;
    chk("first_isBr", isBr, 1'b1);
    chk("first_mispredict", mispredict, 1'b1);
    #1;
    @(posedge clk); #1;
    m_tbl[0] = 2; m_br = 1; m_miss = 1;
    chk("first_f_pred", f_pred_taken, 1'b1);
    chk("first_br_cnt", br_cnt, 32'd1);
    chk("first_miss_cnt", miss_cnt, 32'd1);

    repeat (3) begin
      drive(1, 0, 32'h3000, 1, BEQ, 32'd5, 32'd5);
      cycle();
    end
    chk("sat_br_cnt", br_cnt, 32'd4);
    chk("sat_miss_cnt", miss_cnt, 32'd1);
    f_pc = 32'h3100;
    #1;
    chk("alias_f_pred", f_pred_taken, 1'b1);
    #1;
    // Two not-taken steps from saturation: 3->2 still predicts taken, 2->1 does not.
    drive(1, 0, 32'h3000, 1, BNE, 32'd5, 32'd5);
    cycle();
    chk("desat1_f_pred", f_pred_taken, 1'b1);
    cycle();
    chk("desat2_f_pred", f_pred_taken, 1'b0);

    // Same-cycle lookup and update of one index shows the pre-update value.
    f_pc = 32'h3000;
    drive(1, 0, 32'h3000, 0, BEQ, 32'd7, 32'd7);
    #1;
    chk("nobypass_pre", f_pred_taken, 1'b0);
    #1;
    @(posedge clk); #1;
    m_tbl[0] = 2; m_br++; m_miss++;
    chk("nobypass_post", f_pred_taken, 1'b1);

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      logic [31:0] br_before;
      br_before = br_cnt;
      drive(1, 0, 32'h40 + 32'(i) * 4, vecs[i].pred, vecs[i].op, vecs[i].c1, vecs[i].c2);
      #1;
      chk($sformatf("vec%0d_isBr", i), isBr, vecs[i].exp_br);
      chk($sformatf("vec%0d_mis", i), mispredict, vecs[i].exp_mis);
      #1;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_brcnt", i), br_cnt,
          br_before + ((vecs[i].op == 4'hF || vecs[i].op == 4'h0) ? 32'd0 : 32'd1));
      begin
        logic [1:0] rc;
        rc = ref_cond(vecs[i].op, vecs[i].c1, vecs[i].c2);
        if (rc[1]) begin
          int k;
          k = idx_of(d_pc);
          m_tbl[k] = rc[0] ? ((m_tbl[k] < 3) ? m_tbl[k] + 1 : 3) : ((m_tbl[k] > 0) ? m_tbl[k] - 1 : 0);
          m_br++;
          if (rc[0] != vecs[i].pred) m_miss++;
        end
      end
    end

    // Stall for three cycles, then release once.
    begin
      logic [31:0] br0, miss0;
      br0 = br_cnt; miss0 = miss_cnt;
      drive(1, 1, 32'h3004, 0, BNE, 32'd1, 32'd9);
      repeat (3) begin
        #1;
        chk("stall_isBr", isBr, 1'b1);
        chk("stall_mis", mispredict, 1'b0);
        #1;
        @(posedge clk); #1;
        chk("stall_br_cnt", br_cnt, br0);
      end
      d_stall = 1'b0;
      #1;
      chk("release_mis", mispredict, 1'b1);
      #1;
      @(posedge clk); #1;
      chk("release_br_cnt", br_cnt, br0 + 32'd1);
      chk("release_miss_cnt", miss_cnt, miss0 + 32'd1);
      m_tbl[1] = 2; m_br++; m_miss++;
      drive(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: a = 32'h0;
        1: a = 32'h8000_0000 | 32'($urandom_range(0, 3));
        default: ;
      endcase
      b = ($urandom_range(0, 1) == 1) ? a : $urandom;
      f_pc = {$urandom_range(0, 255), 2'b00} + (32'($urandom) << 10);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            {$urandom_range(0, 15), 2'b00} | (32'($urandom) << 12),
            1'($urandom), 4'($urandom_range(0, 15)), a, b);
      cycle();
    end

    // Async reset mid-cycle after updates.
    f_pc = 32'h3000;
    #2;
    reset = 1'b1;
    #1;
    chk("areset_f_pred", f_pred_taken, 1'b0);
    chk("areset_br_cnt", br_cnt, 32'd0);
    chk("areset_miss_cnt", miss_cnt, 32'd0);
    model_reset();
    begin
      int wrong;
      wrong = 0;
      for (int i = 0; i < 64; i++) begin
        f_pc = 32'(i) << 2;
        #0.01;
        if (f_pred_taken !== 1'b0) wrong++;
      end
      chk("areset_all_entries", 32'(wrong), 32'd0);
    end
    drive(1, 0, 32'h3000, 0, BEQ, 32'd1, 32'd1);
    @(posedge clk); #1;
    chk("reset_edge_no_update", br_cnt, 32'd0);
    reset = 1'b0;
    drive(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    f_pc = 32'h3000;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_branch_predict_cmp.md
# d_branch_predict_cmp

Parametrised decode-stage branch resolver for the five-stage MIPS pipeline. It evaluates branch conditions on operands of configurable width and keeps a PC-indexed table of 2-bit saturating counters that predicts direction at fetch. It reports mispredictions so D can redirect F, and it keeps saturating statistics counters.

## Interface
Parameters:
- WIDTH, 32, operand width of cmp1/cmp2 (≥2).
- IDX_BITS, 6, table index width; 2^IDX_BITS counters.
- CTR_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- f_pc  in  32  fetch PC used for lookup.
- f_pred_taken  out  1  prediction for f_pc; combinational.
- d_valid  in  1  D holds a real instruction.
- d_stall  in  1  D is stalled this cycle.
- d_pc  in  32  PC of the instruction in D.
- d_pred_taken  in  1  prediction carried down from F with the instruction.
- brOp  in  4  condition select; `cmp_*` codes from const.v.
- cmp1, cmp2  in  WIDTH  forwarded operands.
- isBr  out  1  condition result; combinational.
- mispredict  out  1  D-stage redirect request; combinational.
- br_cnt  out  32  count of resolved branches.
- miss_cnt  out  32  count of mispredicted branches.

## Operation
- Condition evaluation (signed over WIDTH bits):
  - `cmp_beq`: cmp1==cmp2.
  - `cmp_bne`: cmp1!=cmp2.
  - `cmp_bgez`/`cmp_bgezal`: cmp1≥0.
  - `cmp_bgtz`: cmp1>0.
  - `cmp_blez`: cmp1≤0.
  - `cmp_bltz`/`cmp_bltzal`: cmp1<0.
  - Any other brOp: isBr=0 and is_branch=0.
- isBr depends only on brOp, cmp1 and cmp2; it is independent of d_valid and d_stall.
- Indexing: f_idx = f_pc[IDX_BITS+1:2], d_idx = d_pc[IDX_BITS+1:2]. Upper PC bits are ignored, so aliasing is permitted.
- f_pred_taken = table[f_idx][1].
- qualified = d_valid & ~d_stall & is_branch.
- mispredict = qualified & (isBr != d_pred_taken).
- On a clock edge with qualified=1:
  - table[d_idx]: if isBr, increment, saturating at 2'b11; else decrement, saturating at 2'b00.
  - br_cnt increments, saturating at 32'hFFFF_FFFF.
  - miss_cnt increments when mispredict=1, saturating at 32'hFFFF_FFFF.
- When qualified=0, no state changes.

## Timing
- Reset values:
  - Every table entry = CTR_INIT.
  - br_cnt = 0, miss_cnt = 0.
  - f_pred_taken = CTR_INIT[1] (0 by default).
  - isBr and mispredict follow their inputs (combinational).
- Reset asserted mid-operation clears the table and counters immediately; no update is taken on the edge where reset is high.
- Latency:
  - isBr, mispredict and f_pred_taken: 0 cycles (combinational).
  - A counter update is visible on f_pred_taken the cycle after the qualifying edge.
- Same-cycle lookup and update of one index: f_pred_taken shows the pre-update value (no bypass).
- During a stall, isBr and the raw condition remain valid, but mispredict=0 and nothing updates. The branch is counted exactly once, on the cycle it leaves D.
- Consecutive qualified branches on consecutive cycles each update; no back-pressure.

## Test plan
- Reset, then f_pc=0x3000 → f_pred_taken=0, br_cnt=0, miss_cnt=0.
- D: pc=0x3000, `cmp_beq`, cmp1=cmp2=5, d_pred_taken=0, d_valid=1, d_stall=0 → isBr=1, mispredict=1. Next cycle: entry0=2'b10, f_pred_taken(0x3000)=1, br_cnt=1, miss_cnt=1.
- Repeat the taken branch at 0x3000 three more times with d_pred_taken=1 → mispredict=0 each time; entry saturates at 2'b11; br_cnt=4, miss_cnt=1. Then f_pc=0x3100 (aliases to index 0) → f_pred_taken=1.
- `cmp_bltz` with cmp1=0x8000_0000 → isBr=1. `cmp_bgtz` with cmp1=0 → isBr=0. `cmp_blez` with cmp1=0 → isBr=1. brOp=0xF → isBr=0 and no counter change.
- Qualified branch held with d_stall=1 for 3 cycles, then d_stall=0 for 1 cycle → mispredict only on the release cycle; br_cnt increments by exactly 1.
- Assert reset asynchronously mid-cycle after updates → all entries return to CTR_INIT and br_cnt=miss_cnt=0 before the next clock edge.
